// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent timer/counter channels behind one word-addressed
// register window. Each channel: CTRL, PRESET, COUNT, STATUS.
// Optional build macro TIMER_BANK_PRESCALE_EN adds an 8-bit per-channel
// prescaler programmed through CTRL[15:8].
module timer_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [3:0]        ByteEn,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);
    localparam int CH_W = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    logic [1:0]        reg_sel;
    logic [CH_W-1:0]   ch_sel;
    logic [31:0]       be_mask;
    logic              lint_unused;

    state_t            state_q    [NUM_CH];
    logic [CNT_W-1:0]  preset_q   [NUM_CH];
    logic [CNT_W-1:0]  count_q    [NUM_CH];
    logic [CNT_W-1:0]  preset_nxt [NUM_CH];
    logic [1:0]        mode_q     [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] im_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_preset;
    logic [NUM_CH-1:0] wr_status;
`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0]        psc_q      [NUM_CH];
    logic [7:0]        pcnt_q     [NUM_CH];
`endif

    assign reg_sel     = Addr[1:0];
    assign ch_sel      = Addr[CH_W+1:2];
    assign be_mask     = {{8{ByteEn[3]}}, {8{ByteEn[2]}}, {8{ByteEn[1]}}, {8{ByteEn[0]}}};
    assign lint_unused = ^{Addr, Din, be_mask};

    // Per-channel write strobes and byte-lane merge of the PRESET write data
    always_comb begin
        wr_ctrl   = '0;
        wr_preset = '0;
        wr_status = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_ctrl[i]    = WE && (ch_sel == i[CH_W-1:0]) && (reg_sel == 2'd0);
            wr_preset[i]  = WE && (ch_sel == i[CH_W-1:0]) && (reg_sel == 2'd1);
            wr_status[i]  = WE && (ch_sel == i[CH_W-1:0]) && (reg_sel == 2'd3);
            preset_nxt[i] = (preset_q[i] & ~be_mask[CNT_W-1:0]) |
                            (Din[CNT_W-1:0] & be_mask[CNT_W-1:0]);
        end
    end

    // Count-enable pulse per channel: every cycle, or once per PSC+1 cycles
    always_comb begin
        tick = '1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef TIMER_BANK_PRESCALE_EN
            tick[i] = (pcnt_q[i] == psc_q[i]);
`else
            tick[i] = 1'b1;
`endif
        end
    end

    // Combinational read mux; unmatched (out-of-range) channels read as zero
    always_comb begin
        Dout = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_sel == i[CH_W-1:0]) begin
                case (reg_sel)
                    2'd0: begin
                        Dout[0]   = en_q[i];
                        Dout[2:1] = mode_q[i];
                        Dout[3]   = im_q[i];
`ifdef TIMER_BANK_PRESCALE_EN
                        Dout[15:8] = psc_q[i];
`endif
                    end
                    2'd1:    Dout[CNT_W-1:0] = preset_q[i];
                    2'd2:    Dout[CNT_W-1:0] = count_q[i];
                    default: Dout[0]         = pend_q[i];
                endcase
            end
        end
    end

    // Channel FSMs and register file; later assignments give software CTRL
    // writes priority over the INT-state EN clear, and the hardware PEND set
    // priority over a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= S_IDLE;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
                mode_q[i]   <= '0;
`ifdef TIMER_BANK_PRESCALE_EN
                psc_q[i]    <= '0;
                pcnt_q[i]   <= '0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    S_IDLE: begin
                        if (en_q[i]) state_q[i] <= S_LOAD;
                    end
                    S_LOAD: begin
                        count_q[i] <= (mode_q[i] == 2'd2) ? '0 : preset_q[i];
`ifdef TIMER_BANK_PRESCALE_EN
                        pcnt_q[i]  <= '0;
`endif
                        state_q[i] <= S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q[i]) begin
                            state_q[i] <= S_IDLE;
                        end else if (tick[i]) begin
`ifdef TIMER_BANK_PRESCALE_EN
                            pcnt_q[i] <= '0;
`endif
                            if (mode_q[i] == 2'd2) begin
                                count_q[i] <= count_q[i] + CNT_W'(1);
                            end else if (count_q[i] <= CNT_W'(1)) begin
                                count_q[i] <= '0;
                                state_q[i] <= S_INT;
                            end else begin
                                count_q[i] <= count_q[i] - CNT_W'(1);
                            end
                        end else begin
`ifdef TIMER_BANK_PRESCALE_EN
                            pcnt_q[i] <= pcnt_q[i] + 8'd1;
`endif
                        end
                    end
                    default: begin
                        if (mode_q[i] == 2'd1) begin
                            state_q[i] <= S_LOAD;
                        end else begin
                            en_q[i]    <= 1'b0;
                            state_q[i] <= S_IDLE;
                        end
                    end
                endcase

                if (wr_ctrl[i] && ByteEn[0]) begin
                    en_q[i]   <= Din[0];
                    mode_q[i] <= Din[2:1];
                    im_q[i]   <= Din[3];
                end
`ifdef TIMER_BANK_PRESCALE_EN
                if (wr_ctrl[i] && ByteEn[1]) psc_q[i] <= Din[15:8];
`endif
                if (wr_preset[i]) preset_q[i] <= preset_nxt[i];
                if (wr_status[i] && ByteEn[0] && Din[0]) pend_q[i] <= 1'b0;
                if (state_q[i] == S_INT) pend_q[i] <= 1'b1;
            end
        end
    end

    assign IRQ     = pend_q & im_q;
    assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a register-access vector table plus
// hand-timed sequences for one-shot, auto-reload, collisions, wrap, reset.
module tb_timer_bank;
    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  irq;
    logic        irq_any;
    logic [29:0] addr8;
    logic        we8;
    logic [3:0]  be8;
    logic [31:0] din8;
    logic [31:0] dout8;
    logic [0:0]  irq8;
    logic        irq_any8;

    int vectors;
    int miscompares;

    localparam logic [29:0] CH0 = 30'd0;
    localparam logic [29:0] CH1 = 30'd4;
    localparam logic [29:0] CH2 = 30'd8;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl [21];

    timer_bank #(.NUM_CH(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Addr(addr), .WE(we), .ByteEn(be), .Din(din),
        .Dout(dout), .IRQ(irq), .IRQ_any(irq_any)
    );

    timer_bank #(.NUM_CH(1), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .Addr(addr8), .WE(we8), .ByteEn(be8), .Din(din8),
        .Dout(dout8), .IRQ(irq8), .IRQ_any(irq_any8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; din = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0; be = 4'h0;
    endtask

    task automatic wr8(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr8 = a; din8 = d; be8 = b; we8 = 1'b1;
        @(negedge clk);
        we8 = 1'b0; be8 = 4'h0;
    endtask

    task automatic rd(input string n, input logic [29:0] a, input logic [31:0] e);
        addr = a;
        #1;
        check(n, dout, e);
    endtask

    task automatic rd8(input string n, input logic [29:0] a, input logic [31:0] e);
        addr8 = a;
        #1;
        check(n, dout8, e);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0;
        addr = '0; we = 1'b0; be = '0; din = '0;
        addr8 = '0; we8 = 1'b0; be8 = '0; din8 = '0;

        // register-access vectors: Dout is sampled before the edge that commits the row
        tbl[0]  = '{30'h001, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{30'h001, 1'b1, 4'h3, 32'hAABB_CCDD, 32'h0000_0000};
        tbl[2]  = '{30'h001, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_CCDD};
        tbl[3]  = '{30'h001, 1'b1, 4'hC, 32'h1122_3344, 32'h0000_CCDD};
        tbl[4]  = '{30'h001, 1'b0, 4'h0, 32'h0000_0000, 32'h1122_CCDD};
        tbl[5]  = '{30'h000, 1'b1, 4'hF, 32'hFFFF_00F6, 32'h0000_0000};
        tbl[6]  = '{30'h000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0006};
        tbl[7]  = '{30'h000, 1'b1, 4'h0, 32'h0000_0000, 32'h0000_0006};
        tbl[8]  = '{30'h000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0006};
        tbl[9]  = '{30'h002, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_0000};
        tbl[10] = '{30'h002, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{30'h00D, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{30'h00D, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[13] = '{30'h009, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[14] = '{30'h009, 1'b1, 4'hF, 32'hCAFE_0001, 32'h0000_0000};
        tbl[15] = '{30'h109, 1'b0, 4'h0, 32'h0000_0000, 32'hCAFE_0001};
        tbl[16] = '{30'h003, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[17] = '{30'h003, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[18] = '{30'h000, 1'b1, 4'h1, 32'h0000_0000, 32'h0000_0006};
        tbl[19] = '{30'h000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[20] = '{30'h001, 1'b0, 4'h0, 32'h0000_0000, 32'h1122_CCDD};

        // reset state
        step(3);
        reset = 1'b1;
        step(2);
        rd("reset_ctrl", CH0 + 0, 32'h0);
        rd("reset_preset", CH1 + 1, 32'h0);
        rd("reset_count", CH2 + 2, 32'h0);
        check("reset_irq", {29'd0, irq}, 32'h0);
        check("reset_irq_any", {31'd0, irq_any}, 32'h0);

        // table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            addr = tbl[i].addr; we = tbl[i].we; be = tbl[i].be; din = tbl[i].din;
            #1;
            check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            check($sformatf("tbl%0d_irq", i), {29'd0, irq}, 32'h0);
        end
        @(negedge clk);
        we = 1'b0; be = 4'h0;

        // one-shot on ch0: P=5
        wr(CH0 + 1, 32'd5, 4'hF);
        wr(CH0 + 0, 32'h9, 4'h1);
        step(1);
        rd("os_count_e1", CH0 + 2, 32'd0);
        step(1);
        rd("os_count_e2", CH0 + 2, 32'd5);
        step(5);
        rd("os_count_e7", CH0 + 2, 32'd0);
        rd("os_pend_e7", CH0 + 3, 32'd0);
        step(1);
        rd("os_pend_e8", CH0 + 3, 32'd1);
        rd("os_ctrl_e8", CH0 + 0, 32'h8);
        check("os_irq_e8", {29'd0, irq}, 32'h1);
        check("os_irq_any_e8", {31'd0, irq_any}, 32'h1);
        step(3);
        rd("os_count_held", CH0 + 2, 32'd0);
        wr(CH0 + 3, 32'h1, 4'h1);
        rd("os_w1c", CH0 + 3, 32'd0);
        check("os_irq_cleared", {29'd0, irq}, 32'h0);

        // auto-reload on ch1: P=3, period 5
        wr(CH1 + 1, 32'd3, 4'hF);
        wr(CH1 + 0, 32'hB, 4'h1);
        step(5);
        rd("ar_pend_e5", CH1 + 3, 32'd0);
        step(1);
        rd("ar_pend_e6", CH1 + 3, 32'd1);
        check("ar_irq_e6", {29'd0, irq}, 32'h2);
        step(1);
        rd("ar_count_e7", CH1 + 2, 32'd3);
        wr(CH1 + 3, 32'h1, 4'h1);
        rd("ar_w1c_e9", CH1 + 3, 32'd0);
        step(1);
        rd("ar_pend_e10", CH1 + 3, 32'd0);
        step(1);
        rd("ar_pend_e11", CH1 + 3, 32'd1);
        wr(CH1 + 3, 32'h1, 4'h1);
        rd("ar_w1c_e13", CH1 + 3, 32'd0);
        step(1);
        wr(CH1 + 3, 32'h1, 4'h1);
        rd("collision_pend", CH1 + 3, 32'd1);
        wr(CH1 + 0, 32'h0, 4'h1);
        wr(CH1 + 3, 32'h1, 4'h1);
        rd("ar_count_held", CH1 + 2, 32'd2);
        rd("ar_pend_off", CH1 + 3, 32'd0);

        // ch2: software CTRL write on the INT edge keeps EN; masked PEND still latches
        wr(CH2 + 1, 32'd1, 4'hF);
        wr(CH2 + 0, 32'h1, 4'h1);
        step(2);
        rd("sw_count_e2", CH2 + 2, 32'd1);
        wr(CH2 + 0, 32'h1, 4'h1);
        rd("sw_ctrl_wins", CH2 + 0, 32'h1);
        rd("sw_pend_masked", CH2 + 3, 32'd1);
        check("sw_irq_masked", {29'd0, irq}, 32'h0);
        wr(CH2 + 0, 32'h0, 4'h1);
        wr(CH2 + 3, 32'h1, 4'h1);
        rd("sw_pend_off", CH2 + 3, 32'd0);

        // 8-bit free-run wrap on dut8
        wr8(30'h0, 32'h5, 4'h1);
        step(257);
        rd8("fr_count_ff", 30'h2, 32'h0000_00FF);
        step(1);
        rd8("fr_count_wrap", 30'h2, 32'h0000_0000);
        rd8("fr_pend", 30'h3, 32'h0);
        check("fr_irq", {31'd0, irq8}, 32'h0);
        wr8(30'h5, 32'hFF, 4'hF);
        rd8("oor_read", 30'h5, 32'h0);
        rd8("oor_no_alias", 30'h1, 32'h0);

        // re-enable with PSC=2 (prescaler only present when the build macro is set)
        wr8(30'h0, 32'h0, 4'h1);
        wr8(30'h0, 32'h0205, 4'h3);
`ifdef TIMER_BANK_PRESCALE_EN
        rd8("psc_ctrl", 30'h0, 32'h0205);
        step(5);
        rd8("psc_count_e5", 30'h2, 32'd1);
        step(2);
        rd8("psc_count_e7", 30'h2, 32'd1);
        step(1);
        rd8("psc_count_e8", 30'h2, 32'd2);
`else
        rd8("psc_ctrl", 30'h0, 32'h0005);
        step(5);
        rd8("psc_count_e5", 30'h2, 32'd3);
        step(2);
        rd8("psc_count_e7", 30'h2, 32'd5);
        step(1);
        rd8("psc_count_e8", 30'h2, 32'd6);
`endif

        // asynchronous reset mid-count with IRQ asserted
        wr(CH0 + 1, 32'd3, 4'hF);
        wr(CH0 + 0, 32'hB, 4'h1);
        step(7);
        rd("rst_pre_count", CH0 + 2, 32'd3);
        check("rst_pre_irq", {29'd0, irq}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_irq", {29'd0, irq}, 32'h0);
        check("rst_async_irq_any", {31'd0, irq_any}, 32'h0);
        rd("rst_async_ctrl", CH0 + 0, 32'h0);
        step(2);
        rd("rst_async_preset", CH0 + 1, 32'h0);
        reset = 1'b1;
        step(3);
        rd("rst_idle_count", CH0 + 2, 32'h0);
        rd("rst_idle_pend", CH0 + 3, 32'h0);
        rd8("rst_dut8_ctrl", 30'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer/counter peripheral for the MIPS SoC. It sits behind the processor bus bridge as one memory-mapped device and replaces the pair of fixed single-channel 32-bit timers with one bank of NUM_CH independent channels. Each channel has:
- a configurable counter width;
- one-shot, auto-reload and free-running modes;
- byte-enabled writes;
- a write-1-to-clear interrupt pending bit.

Per-channel IRQs and their OR are fed to the CPU hardware-interrupt vector.

## Interface
Parameters:
- NUM_CH, 2, number of channels (1..16).
- CNT_W, 32, counter/preset width in bits (8..32).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Addr  in  30  word address (byte address bits [31:2]); the bridge has already selected this device.
- WE  in  1  write strobe, qualified by ByteEn.
- ByteEn  in  4  byte enables for the write.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr and register state.
- IRQ  out  NUM_CH  per-channel interrupt: PEND & IM.
- IRQ_any  out  1  OR of IRQ.

## Operation
Address decode:
- Register select: reg = Addr[1:0].
- Channel select: ch = Addr[1+CH_W:2], where CH_W = max(1, clog2(NUM_CH)).
- Higher Addr bits are ignored.
- ch >= NUM_CH: reads return 0; writes are ignored.

Registers per channel:
- reg 0 CTRL: [0] EN, [2:1] MODE, [3] IM. Other bits read 0.
- reg 1 PRESET: CNT_W bits, read/write.
- reg 2 COUNT: read-only; writes are ignored.
- reg 3 STATUS: [0] PEND. Writing 1 to bit 0 with ByteEn[0] set clears it.

General rules:
- Register values narrower than 32 bits are zero-extended on read and truncated on write.
- Each byte lane is written only when its ByteEn bit is set.

Modes:
- 0 one-shot.
- 1 auto-reload.
- 2 free-run: COUNT increments each tick, wraps 2^CNT_W-1 -> 0, never raises PEND.
- 3 behaves as 0.

Per-channel FSM (IDLE, LOAD, CNT, INT):
- IDLE: if EN -> LOAD.
- LOAD: COUNT <= PRESET (0 in mode 2) -> CNT.
- CNT:
  - if !EN -> IDLE, COUNT held;
  - else if mode 2, COUNT+1;
  - else if COUNT <= 1, COUNT <= 0 -> INT;
  - else COUNT-1.
- INT: PEND <= 1. Mode 0: EN <= 0 -> IDLE. Mode 1: -> LOAD.

Boundary rules:
- PEND set by hardware and W1C in the same cycle: set wins.
- The INT-state EN clear and a software CTRL write in the same cycle: the software write wins.
- PRESET written during CNT is used only at the next LOAD.
- MODE change takes effect on the next clock.
- IM affects IRQ only; PEND still latches while masked.
- Clearing EN mid-count, then setting EN again, restarts from LOAD.

## Timing
- Reset (async assert, sync release): all CTRL, PRESET, COUNT, PEND = 0; every FSM in IDLE; IRQ = 0; IRQ_any = 0; Dout reflects the reset registers.
- Write with EN=1 at edge 0 (PRESET = P, mode 0/1):
  - edge 1: LOAD;
  - edge 2: COUNT = P, state CNT;
  - COUNT reaches 0 at edge 2+max(P,1);
  - PEND = 1 after edge 3+max(P,1).
- Mode 1 reload period: max(P,1)+2 cycles between PEND set events.
- Register writes are visible on Dout the cycle after the write edge.
- IRQ is combinational from PEND & IM.

## Configuration
- TIMER_BANK_PRESCALE_EN defined:
  - CTRL[15:8] is PSC, read/write;
  - each channel has an 8-bit prescale counter, cleared on LOAD;
  - COUNT moves (decrement or increment) only when the prescale counter equals PSC, at which point it resets to 0;
  - a tick therefore occurs every PSC+1 cycles;
  - the LOAD and INT states are unaffected.
- Undefined: CTRL[15:8] reads 0, writes to it are ignored, and COUNT moves every cycle in CNT.

## Test plan
- Reset: assert reset low mid-count -> all registers 0, IRQ = 0 immediately without a clock; release -> FSMs in IDLE.
- One-shot: ch0, PRESET = 5, CTRL = 0x9 (EN, mode 0, IM) -> COUNT = 5 at edge 2, 0 at edge 7; PEND and IRQ[0] = 1 after edge 8; EN reads 0; COUNT stays 0.
- Auto-reload: ch1, PRESET = 3, CTRL = 0xB -> PEND rises at edge 6; COUNT = 3 again at edge 7; write 1 to STATUS -> PEND = 0; it re-asserts 5 cycles after the previous set.
- Collision: W1C of PEND issued on the exact edge hardware sets PEND -> PEND = 1.
- Byte enables and decode: write 0xAABBCCDD to PRESET with ByteEn = 4'b0011 -> reads 0x0000CCDD; a write to COUNT or to ch = NUM_CH -> no state change, and the out-of-range read returns 0.
- Free-run wrap (CNT_W = 8, mode 2) -> COUNT 0xFF -> 0x00 with PEND remaining 0. With TIMER_BANK_PRESCALE_EN and PSC = 2 -> COUNT increments every 3 cycles.
